dmem_banked_rw: RTL and testbench
=================================

// Module: dmem_banked_rw
// PURPOSE
//  Parametrised data memory for the RV32 core: byte/half/word loads and stores with RISC-V funct3 sizing,
//  sign/zero extension, misalign and range error reporting, valid/ready request handshake, registered response.
//  Contents are cleared by a sequential clear engine, one word per cycle, after reset or on demand.
//  Sits between the execute/mem stage and the memory array; it replaces the single-cycle word-only data memory.
// PARAMETERS
//  ADDR_W       32   byte address width
//  DATA_W       32   word width; fixed at 32 for RV32
//  DEPTH_WORDS  64   number of words; must be a power of 2, >= 2
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous, active-high
//  clear_start  in   1        1-cycle pulse; restarts the clear engine
//  busy         out  1        1 while the clear engine runs
//  req_valid    in   1        request present
//  req_ready    out  1        request accepted when valid & ready
//  req_we       in   1        1 = store, 0 = load
//  req_funct3   in   3        000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
//  req_addr     in   ADDR_W   byte address
//  req_wdata    in   DATA_W   store data; the low bytes are used per size
//  resp_valid   out  1        1-cycle pulse; response for the accepted request
//  resp_rdata   out  DATA_W   extended load data; 0 for stores and errors
//  resp_err     out  1        misaligned, out-of-range or illegal funct3
// BEHAVIOUR
//  Reset (async): state=CLEAR, clr_idx=0, busy=1, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
//   An in-flight response is dropped.
//  FSM states are CLEAR and IDLE.
//   CLEAR: write 0 to word clr_idx each cycle, then clr_idx++. After the write to DEPTH_WORDS-1, go to IDLE.
//   A full clear takes exactly DEPTH_WORDS cycles.
//   IDLE: req_ready=1 unless clear_start=1 that cycle.
//   clear_start in IDLE -> CLEAR with clr_idx=0.
//   clear_start in CLEAR -> clr_idx restarts at 0.
//   clear_start has priority over a same-cycle req_valid; that request is not accepted.
//  Accept: req_valid & req_ready at a posedge.
//   Response registered; resp_valid asserts the next cycle for exactly 1 cycle. Throughput is 1 req/cycle.
//   resp_valid has no backpressure.
//  Word index = req_addr[log2(DEPTH_WORDS)+1:2]; byte lane = req_addr[1:0].
//  Errors (resp_err=1, memory unchanged, resp_rdata=0):
//   - H/HU with addr[0]=1; W with addr[1:0]!=0
//   - req_addr[ADDR_W-1:log2(DEPTH_WORDS)+2] != 0 (out of range)
//   - funct3 not in the legal set; for stores, funct3 not in {000,001,010}
//  Store: byte-enable write of the addressed lane(s) only; the other bytes keep their value.
//   SB writes wdata[7:0] to the lane; SH writes wdata[15:0] to lanes {a1,0} and {a1,1}.
//  Load: read the word at accept, select the lane and extend. B/H sign-extend; BU/HU zero-extend; W passes through.
//  Load after store to the same address in the next cycle returns the new data (store completes at its accept edge).
//  Loads and stores are never accepted while busy.
// STRUCTURE
//  Package dmem_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum {CLEAR, IDLE},
//   byte-enable width localparam.
//  Sub-module dmem_lane_align (combinational):
//   funct3, addr[1:0], wdata, rword -> byte-enable[3:0], shifted wdata, extended rdata, misalign flag.
//  The array is reg [DATA_W-1:0] mem [0:DEPTH_WORDS-1], written per byte enable.
// TESTING
//  1. Reset, then poll -> busy=1 and req_ready=0 for exactly 64 cycles, then 1; a LW from every word returns 0.
//  2. SW 0x8000_00F1 @0x10; LB @0x10; LBU @0x10; LH @0x12; LHU @0x12
//     -> 0xFFFF_FFF1, 0x0000_00F1, 0xFFFF_8000, 0x0000_8000; each resp_valid 1 cycle after accept.
//  3. SW 0x1122_3344 @0x20, SB 0xAA @0x21, SH 0xBEEF @0x22; LW @0x20 -> 0xBEEF_AA44.
//  4. LW @0x06, SH @0x03, LW @0x100 (DEPTH 64), funct3=011
//     -> resp_err=1, rdata=0; a later LW @0x04 shows the memory unchanged.
//  5. clear_start asserted in the same cycle as req_valid=1 -> request not accepted, busy for 64 cycles,
//     previously written data reads 0.
//  6. Reset asserted the cycle after a LW accept -> no resp_valid; busy=1 immediately; clear runs from word 0.
//     Back-to-back SW/LW to the same address on consecutive cycles -> the LW returns the stored data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and types for the banked RV32 data memory.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WORD_W = 32;
    localparam int BE_W   = WORD_W / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32 loads/stores: byte enables, replicated store data,
// extended load data and size-based error flags.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_lane,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [WORD_W-1:0] i_rword,
    output logic [BE_W-1:0]   o_be,
    output logic [WORD_W-1:0] o_wdata,
    output logic [WORD_W-1:0] o_rdata,
    output logic              o_misalign,
    output logic              o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        o_be       = '0;
        o_wdata    = i_wdata;
        o_rdata    = '0;
        o_misalign = 1'b0;
        o_illegal  = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_byte[7]}}, w_byte};
            end
            F3_BU: begin
                o_illegal = i_we;
                o_rdata   = {24'b0, w_byte};
            end
            F3_H: begin
                o_be       = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{w_half[15]}}, w_half};
                o_misalign = i_lane[0];
            end
            F3_HU: begin
                o_illegal  = i_we;
                o_rdata    = {16'b0, w_half};
                o_misalign = i_lane[0];
            end
            F3_W: begin
                o_be       = '1;
                o_rdata    = i_rword;
                o_misalign = |i_lane;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_banked_rw.sv
// RV32 data memory with sized loads/stores, error reporting, registered response
// and a one-word-per-cycle clear engine that runs after reset or on request.
module dmem_banked_rw
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_start,
    output logic              busy,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int               IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    logic [DATA_W-1:0] r_mem [0:DEPTH_WORDS-1];
    state_t            r_state;
    logic [IDX_W-1:0]  r_clr_idx;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;

    logic [IDX_W-1:0]  w_idx;
    logic              w_oor;
    logic              w_accept;
    logic              w_err;
    logic              w_store;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata_sh;
    logic [DATA_W-1:0] w_rdata_ext;
    logic              w_misalign;
    logic              w_illegal;

    assign w_idx     = req_addr[IDX_W+1:2];
    assign w_oor     = |req_addr[ADDR_W-1:IDX_W+2];
    assign busy      = (r_state == CLEAR);
    assign req_ready = (r_state == IDLE) && !clear_start;
    assign w_accept  = req_valid && req_ready;
    assign w_err     = w_misalign || w_illegal || w_oor;
    assign w_store   = w_accept && req_we && !w_err;

    dmem_lane_align u_align (
        .i_we       (req_we),
        .i_funct3   (req_funct3),
        .i_lane     (req_addr[1:0]),
        .i_wdata    (req_wdata),
        .i_rword    (r_mem[w_idx]),
        .o_be       (w_be),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_rdata_ext),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
        end else if (r_state == CLEAR) begin
            if (clear_start) begin
                r_clr_idx <= '0;
            end else if (r_clr_idx == LAST_IDX) begin
                r_state   <= IDLE;
                r_clr_idx <= '0;
            end else begin
                r_clr_idx <= r_clr_idx + 1'b1;
            end
        end else if (clear_start) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
        end
    end

    // NOTE: the array has no reset; the clear engine zeroes it word by word instead.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_store) begin
            for (int b = 0; b < BE_W; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= w_accept;
            r_resp_rdata <= (w_accept && !req_we && !w_err) ? w_rdata_ext : '0;
            r_resp_err   <= w_accept && w_err;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_banked_rw.sv
// Scoreboard bench for dmem_banked_rw: expectations queued at request time, compared on resp_valid.
module tb_dmem_banked_rw;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_start;
    logic        busy;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    dmem_banked_rw #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear_start (clear_start),
        .busy        (busy),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Response monitor: every resp_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (resp_valid === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: resp_valid=1 rdata=%h err=%b, expected no response",
                             resp_rdata, resp_err);
                end else begin
                    e = sb_q.pop_front();
                    if (resp_rdata !== e.rdata || resp_err !== e.err || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL %s: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d",
                                 e.name, resp_rdata, resp_err, cyc, e.rdata, e.err, e.cyc);
                    end
                end
            end else if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
                e = sb_q.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: no resp_valid at cyc=%0d, expected response", e.name, e.cyc);
            end
        end
    end

    // Called at a negedge; the request is accepted at the next posedge.
    task automatic drive(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: req_ready=%b, expected 1", name, req_ready);
        end
        sb_q.push_back('{exp_rdata, exp_err, cyc + 1, name});
        @(negedge clk);
    endtask

    task automatic drain();
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        bit ready_seen = 0;
        while (busy === 1'b1 && n < 200) begin
            if (req_ready !== 1'b0) ready_seen = 1;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL %s_busy_len: busy cycles=%0d, expected 64", name, n);
        end
        checks++;
        if (ready_seen) begin
            errors++;
            $display("FAIL %s_ready_while_busy: req_ready=1 seen, expected 0", name);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_after: req_ready=%b, expected 1", name, req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = F3_W; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0 ||
            resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b ready=%b rv=%b rdata=%h err=%b, expected 1 0 0 0 0",
                     busy, req_ready, resp_valid, resp_rdata, resp_err);
        end
        reset = 1'b0;
        count_busy("reset");
        for (int i = 0; i < 64; i++)
            drive($sformatf("lw_cleared_%0d", i), 1'b0, F3_W, 32'(i * 4), 32'h0, 32'h0, 1'b0);
        drain();
    endtask

    task automatic test_sizes();
        drive("sw_10",  1'b1, F3_W,  32'h10, 32'h8000_00F1, 32'h0, 1'b0);
        drive("lb_10",  1'b0, F3_B,  32'h10, 32'h0, 32'hFFFF_FFF1, 1'b0);
        drive("lbu_10", 1'b0, F3_BU, 32'h10, 32'h0, 32'h0000_00F1, 1'b0);
        drive("lh_12",  1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF_8000, 1'b0);
        drive("lhu_12", 1'b0, F3_HU, 32'h12, 32'h0, 32'h0000_8000, 1'b0);
        drive("lb_13",  1'b0, F3_B,  32'h13, 32'h0, 32'hFFFF_FF80, 1'b0);
        drive("lh_10",  1'b0, F3_H,  32'h10, 32'h0, 32'h0000_00F1, 1'b0);
        drain();
    endtask

    task automatic test_byte_enable();
        drive("sw_20",  1'b1, F3_W, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
        drive("sb_21",  1'b1, F3_B, 32'h21, 32'hFFFF_FFAA, 32'h0, 1'b0);
        drive("sh_22",  1'b1, F3_H, 32'h22, 32'h1234_BEEF, 32'h0, 1'b0);
        drive("lw_20",  1'b0, F3_W, 32'h20, 32'h0, 32'hBEEF_AA44, 1'b0);
        drain();
    endtask

    task automatic test_errors();
        drive("sw_04",       1'b1, F3_W,   32'h04,  32'hCAFE_F00D, 32'h0, 1'b0);
        drive("lw_mis_06",   1'b0, F3_W,   32'h06,  32'h0,         32'h0, 1'b1);
        drive("sh_mis_03",   1'b1, F3_H,   32'h03,  32'h0000_1111, 32'h0, 1'b1);
        drive("lw_oor_100",  1'b0, F3_W,   32'h100, 32'h0,         32'h0, 1'b1);
        drive("sw_oor_104",  1'b1, F3_W,   32'h104, 32'h2222_2222, 32'h0, 1'b1);
        drive("ld_f3_011",   1'b0, 3'b011, 32'h04,  32'h0,         32'h0, 1'b1);
        drive("st_f3_100",   1'b1, F3_BU,  32'h04,  32'h3333_3333, 32'h0, 1'b1);
        drive("lhu_mis_05",  1'b0, F3_HU,  32'h05,  32'h0,         32'h0, 1'b1);
        drive("lw_04_after", 1'b0, F3_W,   32'h04,  32'h0, 32'hCAFE_F00D, 1'b0);
        drain();
    endtask

    task automatic test_clear_start();
        drive("sw_30", 1'b1, F3_W, 32'h30, 32'h5A5A_A5A5, 32'h0, 1'b0);
        drive("lw_30", 1'b0, F3_W, 32'h30, 32'h0, 32'h5A5A_A5A5, 1'b0);
        clear_start = 1'b1;
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_funct3  = F3_W;
        req_addr    = 32'h30;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_prio_ready: req_ready=%b, expected 0", req_ready);
        end
        @(negedge clk);
        clear_start = 1'b0;
        req_valid   = 1'b0;
        count_busy("clear_start");
        drive("lw_30_cleared", 1'b0, F3_W, 32'h30, 32'h0, 32'h0, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        drive("sw_3c",  1'b1, F3_W,  32'h3C, 32'h0BAD_CAFE, 32'h0, 1'b0);
        drive("lw_3c",  1'b0, F3_W,  32'h3C, 32'h0, 32'h0BAD_CAFE, 1'b0);
        drive("sb_3d",  1'b1, F3_B,  32'h3D, 32'h0000_0077, 32'h0, 1'b0);
        drive("lbu_3d", 1'b0, F3_BU, 32'h3D, 32'h0, 32'h0000_0077, 1'b0);
        drive("lw_3c2", 1'b0, F3_W,  32'h3C, 32'h0, 32'h0BAD_77FE, 1'b0);
        drain();
    endtask

    task automatic test_reset_inflight();
        drive("sw_10b", 1'b1, F3_W, 32'h10, 32'h7654_3210, 32'h0, 1'b0);
        drain();
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 32'h10;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL inflight_ready: req_ready=%b, expected 1", req_ready);
        end
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL inflight_reset: rv=%b busy=%b ready=%b, expected 0 1 0",
                     resp_valid, busy, req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        count_busy("inflight");
        drive("lw_10_cleared", 1'b0, F3_W, 32'h10, 32'h0, 32'h0, 1'b0);
        drive("lw_fc_cleared", 1'b0, F3_W, 32'hFC, 32'h0, 32'h0, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_sizes();
        test_byte_enable();
        test_errors();
        test_clear_start();
        test_back_to_back();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
